// File: rtl/dff_arb_pkg.sv
// Shared types and default parameters for the dff write arbiter.
//   state_t      : sequencer states (IDLE / WRITE / VERIFY)
//   DEF_NUM_REQ  : default number of requesters
//   DEF_WIDTH    : default dff data width
//   DEF_CNT_W    : default width of the saturating statistics counters
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   i_req    : request vector
//   i_last   : index of the previous winner; search starts at i_last+1
//   o_winner : first set request bit searching upward with wrap
//   o_valid  : at least one request is set (o_winner meaningful)
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_valid
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // Walk the candidates in priority order; the first hit wins.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_last) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/dff_wr_arbiter.sv
// Round-robin write arbiter and write/read-back sequencer for a shared dff.
// Ports:
//   clk, reset : system clock (rising edge), async active-high reset
//   req        : per-requester level request, held until done
//   wdata      : packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt        : one-hot grant, high during WRITE and VERIFY
//   done       : high for the VERIFY cycle of each transaction
//   err        : read-back mismatch, meaningful only with done
//   d_out      : drives dff d; changes only at a grant edge
//   q_in       : dff q
//   busy       : sequencer not idle
//   wr_cnt     : completed transactions, saturating
//   err_cnt    : transactions with err, saturating
//
// state  | meaning
// IDLE   | waiting for any request; winner latched on the edge leaving
// WRITE  | dff captures d_out at the end of this cycle
// VERIFY | q_in compared with d_out; done/err valid; counters update
module dff_wr_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     done,
  output logic                     err,
  output logic [WIDTH-1:0]         d_out,
  input  logic [WIDTH-1:0]         q_in,
  output logic                     busy,
  output logic [CNT_W-1:0]         wr_cnt,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_win;
  logic [WIDTH-1:0]   r_d_out;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [IDX_W-1:0]   w_winner;
  logic               w_valid;
  logic               w_done;
  logic               w_err;
  logic               w_busy;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_busy      = (r_state != IDLE);
    case (r_state)
      IDLE:    if (w_valid) w_state_nxt = WRITE;
      WRITE:   w_state_nxt = VERIFY;
      VERIFY: begin
        w_done      = 1'b1;
        w_err       = (q_in != r_d_out);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Hold register, grant and statistics. d_out is only reloaded on a grant
  // so the dff keeps its contents between transactions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt     <= '0;
      r_win     <= '0;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_d_out   <= '0;
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_gnt   <= NUM_REQ'(1) << w_winner;
            r_win   <= w_winner;
            r_d_out <= wdata[w_winner*WIDTH +: WIDTH];
          end
        end
        VERIFY: begin
          r_last <= r_win;
          r_gnt  <= '0;
          if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
          if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = w_done;
  assign err     = w_err;
  assign d_out   = r_d_out;
  assign busy    = w_busy;
  assign wr_cnt  = r_wr_cnt;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_dff_wr_arbiter.sv
// Self-checking bench for dff_wr_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_dff_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int CNT_W   = 8;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*WIDTH-1:0] wdata = '0;
  logic [NUM_REQ-1:0]       gnt;
  logic                     done;
  logic                     err;
  logic [WIDTH-1:0]         d_out;
  logic [WIDTH-1:0]         q_in;
  logic                     busy;
  logic [CNT_W-1:0]         wr_cnt;
  logic [CNT_W-1:0]         err_cnt;

  // Shared dff plus fault injection on its read-back path.
  logic [WIDTH-1:0] dff_q;
  logic             stuck = 1'b0;
  logic [WIDTH-1:0] flip = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dff_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .d_out   (d_out),
    .q_in    (q_in),
    .busy    (busy),
    .wr_cnt  (wr_cnt),
    .err_cnt (err_cnt)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) dff_q <= '0;
    else       dff_q <= d_out;
  end

  assign q_in = stuck ? '0 : (dff_q ^ flip);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transaction is either absent (age -1) or
  // has lived 0 (write cycle) or 1 (verify cycle) edges since its grant.
  int               m_age;
  int               m_win;
  int               m_last;
  int               m_cand;
  logic [WIDTH-1:0] m_d;
  int               m_wr;
  int               m_er;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age = -1; m_win = 0; m_last = NUM_REQ - 1; m_d = '0; m_wr = 0; m_er = 0;
    end else if (m_age == 1) begin
      m_last = m_win;
      if (m_wr < 255) m_wr++;
      if (q_in != m_d && m_er < 255) m_er++;
      m_age = -1;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (req != '0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        m_cand = (m_last + k) % NUM_REQ;
        if (req[m_cand]) begin
          m_win = m_cand;
          break;
        end
      end
      m_d   = wdata[m_win*WIDTH +: WIDTH];
      m_age = 0;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_age >= 0);
    check("gnt", gnt, (m_age >= 0) ? (32'd1 << m_win) : 32'd0);
    check("done", done, m_age == 1);
    if (m_age == 1) check("err", err, q_in != m_d);
    check("d_out", d_out, m_d);
    check("wr_cnt", wr_cnt, m_wr);
    check("err_cnt", err_cnt, m_er);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; stuck = 1'b0; flip = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_d_out", d_out, 0);
    check("rst_wr_cnt", wr_cnt, 0);

    // single write of A by requester 0
    req = 4'b0001; wdata = 16'h000A;
    tick();
    check("t1_gnt", gnt, 4'b0001);
    tick();
    check("t1_q", q_in, 4'hA);
    check("t1_done", done, 1);
    check("t1_err", err, 0);
    req = '0;
    tick();
    check("t1_wr_cnt", wr_cnt, 1);
    check("t1_d_hold", d_out, 4'hA);
    check("t1_model_last", m_last, 0);
    tick(); tick();
    check("t1_d_hold2", d_out, 4'hA);

    // all four requesting: strict rotation 0,1,2,3,0
    do_reset();
    req = 4'b1111; wdata = 16'h4321;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("t2_gnt", gnt, 4'b0001 << (t % 4));
      tick();
      check("t2_q", q_in, (t % 4) + 1);
      check("t2_done", done, 1);
      tick();
    end
    req = '0;
    tick();

    // last=1, then req 3 and 0: 3 wins first, then 0
    do_reset();
    req = 4'b0010; wdata = 16'h0000;
    tick(); tick(); req = '0; tick();
    check("t3_model_last", m_last, 1);
    req = 4'b1001; wdata = 16'h7006;
    tick();
    check("t3_gnt_a", gnt, 4'b1000);
    check("t3_model_win", m_win, 3);
    tick(); tick();
    tick();
    check("t3_gnt_b", gnt, 4'b0001);
    tick(); tick();
    req = '0;
    tick();

    // q stuck at zero
    do_reset();
    stuck = 1'b1;
    req = 4'b0001; wdata = 16'h0005;
    tick(); tick();
    check("t4_done", done, 1);
    check("t4_err", err, 1);
    req = '0;
    tick();
    check("t4_err_cnt", err_cnt, 1);
    check("t4_wr_cnt", wr_cnt, 1);

    // reset during WRITE
    do_reset();
    req = 4'b0001; wdata = 16'h000F;
    tick();
    check("t5_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("t5_gnt", gnt, 0);
    check("t5_busy", busy, 0);
    check("t5_d_out", d_out, 0);
    check("t5_done", done, 0);
    tick();
    reset = 1'b0; req = '0;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("t5_no_done", done, 0);
    end
    check("t5_wr_cnt", wr_cnt, 0);
    check("t5_err_cnt", err_cnt, 0);

    // saturation after 300 failing transactions
    do_reset();
    stuck = 1'b1;
    req = 4'b0001; wdata = 16'h0005;
    for (int t = 0; t < 300 * 3; t++) tick();
    req = '0;
    tick();
    check("t6_wr_sat", wr_cnt, 8'hFF);
    check("t6_err_sat", err_cnt, 8'hFF);
    check("t6_model_sat", m_wr, 255);

    // randomized traffic with read-back corruption and async resets
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      req   = ($urandom_range(0, 3) == 0) ? '0 : NUM_REQ'($urandom_range(0, 15));
      wdata = (NUM_REQ*WIDTH)'($urandom);
      flip  = ($urandom_range(0, 5) == 0) ? WIDTH'($urandom_range(1, 15)) : '0;
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dff_wr_arbiter.md
Name: dff_wr_arbiter

Overview:
- Round-robin write arbiter and sequencer for the shared WIDTH-bit D flip-flop register (dff).
- Grants one of NUM_REQ requesters at a time and drives the dff d input from an internal hold register.
- After the dff captures the value, reads q back, compares it with the written value, and reports done/error to the winning requester.
- Sits between requester agents and the dff in the top level; dff clock and reset are shared with this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, data width of dff d/q
CNT_W, 8, width of saturating write and error counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester write request, level, held until done
wdata  input  NUM_REQ*WIDTH  packed write data; requester i occupies slice [i*WIDTH +: WIDTH]
gnt  output  NUM_REQ  one-hot grant, high during WRITE and VERIFY
done  output  1  high for exactly the VERIFY cycle of each transaction
err  output  1  valid only when done=1; high if q_in != d_out
d_out  output  WIDTH  drives dff d
q_in  input  WIDTH  from dff q
busy  output  1  high when state != IDLE
wr_cnt  output  CNT_W  completed transactions, saturates at all-ones
err_cnt  output  CNT_W  transactions with err=1, saturates at all-ones

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, gnt=0, d_out=0, last=NUM_REQ-1, wr_cnt=0, err_cnt=0.
  - done, err and busy are 0 as a consequence of state=IDLE.
- FSM states: IDLE, WRITE, VERIFY.
- IDLE:
  - If req is nonzero at edge N, select winner w. w is the first set req bit searching upward from last+1 and wrapping modulo NUM_REQ.
  - At edge N: gnt<=onehot(w), d_out<=wdata[w], state<=WRITE.
  - If req=0, stay in IDLE; d_out holds.
- WRITE: the dff captures d_out at edge N+1. state<=VERIFY unconditionally.
- VERIFY:
  - done=1 combinationally.
  - err=(q_in!=d_out) combinationally.
  - At edge N+2: last<=w, gnt<=0, state<=IDLE.
  - At the same edge, wr_cnt increments and err_cnt increments if err, both saturating.
- Latency: req seen at edge N gives done high in the cycle after edge N+1. The earliest next grant is edge N+3.
- Requester drops req at the edge that ends its done cycle. A req still high in IDLE is treated as a new request.
- d_out holds its last written value outside WRITE, so the dff retains its contents; d_out never changes except at a grant edge.
- req or wdata changing after the grant edge has no effect on the current transaction. The transaction always completes even if req drops early.
- Simultaneous requests are resolved strictly round-robin. No requester waits more than NUM_REQ-1 transactions.
- Only the single requester with req high wins, regardless of last.
- Reset mid-transaction: immediate return to reset values; no done pulse and no counter update.
- gnt is never multi-hot; gnt!=0 if and only if busy.

Decomposition:
- Package dff_arb_pkg holds:
  - the state enum typedef (IDLE/WRITE/VERIFY)
  - default parameter constants
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req, last.
  - Outputs: winner index and a valid flag.
- FSM, hold register and counters live in dff_wr_arbiter.

Test Plan:
1. Reset, then req=4'b0001 with wdata[0]=4'hA → gnt=0001 at edge 1, q=A after edge 2, done=1 and err=0 in the following cycle, wr_cnt=1, d_out stays A afterward.
2. req=4'b1111 held continuously after each done, wdata slices 1,2,3,4 (req0=1 … req3=4) from reset → grant order 0,1,2,3,0; q sequence 1,2,3,4,1; a new grant every 3 cycles.
3. last=1, then req=4'b1001 → req3 granted before req0; next transaction grants req0.
4. Force q_in stuck at 0 and write 4'h5 → done=1 with err=1; err_cnt=1, wr_cnt=1.
5. Assert reset during WRITE after granting 4'hF → gnt=0, busy=0, d_out=0 immediately; no done pulse; counters remain 0.
6. Run 300 transactions with forced errors → wr_cnt and err_cnt saturate at 8'hFF and do not wrap.
